// File: rtl/tt_uio_sched_pkg.sv
// Shared types and constants for the uio pad bus scheduler and its picker.
package tt_uio_sched_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_W_DEF     = 8;
    localparam int MAX_BURST_DEF  = 4;
    localparam int TURNAROUND_DEF = 1;

    localparam logic [7:0] OE_ALL_OUT = 8'hFF;
    localparam logic [7:0] OE_ALL_IN  = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tt_uio_bus_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Returns the one-hot winner and its index.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]                    req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    output logic [N-1:0]                    gnt_oh,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
    output logic                            valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] pos;

    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        sum     = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            pos = sum[IW-1:0];
            if (!valid && req[pos]) begin
                valid       = 1'b1;
                gnt_oh[pos] = 1'b1;
                gnt_idx     = pos;
            end
        end
    end

endmodule

// File: rtl/tt_uio_bus_scheduler.sv
// Round-robin owner of the shared uio pad bus: bounded bursts, write/read
// direction per owner, idle turnaround cycles whenever the pad direction flips.
module tt_uio_bus_scheduler
    import tt_uio_sched_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF,
    parameter int TURNAROUND = TURNAROUND_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        dir,
    input  logic [NUM_REQ-1:0]        last,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rdata_valid,
    input  logic [DATA_W-1:0]         uio_in,
    output logic [DATA_W-1:0]         uio_out,
    output logic [DATA_W-1:0]         uio_oe,
    output logic                      busy
);

    localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW        = 4;
    localparam int TW        = 2;
    localparam int TURN_LOAD = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;

    sched_state_e        state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]       turn_cnt_q, turn_cnt_d;
    logic                cur_dir_q, cur_dir_d;
    logic                own_dir_q, own_dir_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   uio_out_q, uio_out_d;
    logic [DATA_W-1:0]   uio_oe_q, uio_oe_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   owner_wdata;
    logic                release_now;
    logic                abort_now;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

    assign owner_wdata = wdata[int'(owner_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        beat_cnt_d    = beat_cnt_q;
        turn_cnt_d    = turn_cnt_q;
        cur_dir_d     = cur_dir_q;
        own_dir_d     = own_dir_q;
        gnt_d         = gnt_q;
        uio_out_d     = uio_out_q;
        uio_oe_d      = uio_oe_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        release_now   = 1'b0;
        abort_now     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ena && pick_valid) begin
                    owner_d   = pick_idx;
                    own_dir_d = dir[pick_idx];
                    if ((dir[pick_idx] != cur_dir_q) && (TURNAROUND > 0)) begin
                        state_d    = TURN;
                        turn_cnt_d = TW'(TURN_LOAD);
                        uio_oe_d   = OE_ALL_IN;
                        uio_out_d  = '0;
                    end else begin
                        state_d   = OWN;
                        gnt_d     = pick_oh;
                        cur_dir_d = dir[pick_idx];
                        uio_oe_d  = dir[pick_idx] ? OE_ALL_OUT : OE_ALL_IN;
                    end
                end
            end
            TURN: begin
                if (!ena) begin
                    abort_now = 1'b1;
                end else if (turn_cnt_q == '0) begin
                    state_d         = OWN;
                    gnt_d           = '0;
                    gnt_d[owner_q]  = 1'b1;
                    cur_dir_d       = own_dir_q;
                    uio_oe_d        = own_dir_q ? OE_ALL_OUT : OE_ALL_IN;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
            OWN: begin
                if (!ena) begin
                    abort_now = 1'b1;
                end else if (!req[owner_q]) begin
                    release_now = 1'b1;
                end else begin
                    if (own_dir_q) begin
                        uio_out_d = owner_wdata;
                    end else begin
                        rdata_d       = uio_in;
                        rdata_valid_d = 1'b1;
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last[owner_q] || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
                        release_now = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_now || abort_now) begin
            state_d    = IDLE;
            gnt_d      = '0;
            beat_cnt_d = '0;
            ptr_d      = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        // An abort leaves the pads released rather than parked in the old direction.
        if (abort_now) begin
            uio_oe_d  = OE_ALL_IN;
            uio_out_d = '0;
            cur_dir_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            beat_cnt_q    <= '0;
            turn_cnt_q    <= '0;
            cur_dir_q     <= 1'b0;
            own_dir_q     <= 1'b0;
            gnt_q         <= '0;
            uio_out_q     <= '0;
            uio_oe_q      <= OE_ALL_IN;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            beat_cnt_q    <= beat_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            cur_dir_q     <= cur_dir_d;
            own_dir_q     <= own_dir_d;
            gnt_q         <= gnt_d;
            uio_out_q     <= uio_out_d;
            uio_oe_q      <= uio_oe_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign gnt         = gnt_q;
    assign uio_out     = uio_out_q;
    assign uio_oe      = uio_oe_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tt_uio_bus_scheduler.sv
// Bench for tt_uio_bus_scheduler: directed vector table, grant rotation
// sequence, then random traffic against a cycle-level reference model.
module tb_tt_uio_bus_scheduler;

    localparam int N  = 4;
    localparam int TA = 1;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req, dir, last;
    logic [31:0] wdata;
    logic [7:0]  uio_in;
    logic [3:0]  gnt;
    logic [7:0]  rdata, uio_out, uio_oe;
    logic        rdata_valid, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tt_uio_bus_scheduler #(
        .NUM_REQ(N), .DATA_W(8), .MAX_BURST(MB), .TURNAROUND(TA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir), .last(last),
        .wdata(wdata), .gnt(gnt), .rdata(rdata), .rdata_valid(rdata_valid),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy)
    );

    typedef struct {
        logic        rst_n;
        logic        ena;
        logic [3:0]  req;
        logic [3:0]  dir;
        logic [3:0]  last;
        logic [31:0] wdata;
        logic [7:0]  uio_in;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_oe;
        logic [7:0]  exp_out;
        logic [7:0]  exp_rdata;
        logic        exp_rv;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[21];

    // Reference model: owner < 0 means no grant in progress; turn_left counts
    // the idle turnaround cycles still to go before the grant appears.
    int          m_owner, m_turn_left, m_ptr, m_beats;
    logic        m_cur_dir, m_own_dir;
    logic [3:0]  e_gnt;
    logic [7:0]  e_oe, e_out, e_rd;
    logic        e_rv, e_busy;

    function automatic logic bit_at(input logic [3:0] v, input int i);
        logic [1:0] s;
        s = 2'(i);
        return v[s];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_grant();
        e_gnt     = 4'(1 << m_owner);
        m_cur_dir = m_own_dir;
        e_oe      = m_own_dir ? 8'hFF : 8'h00;
    endtask

    task automatic m_drop(input bit abort);
        e_gnt       = 4'h0;
        e_busy      = 1'b0;
        m_ptr       = (m_owner + 1) % N;
        m_owner     = -1;
        m_turn_left = 0;
        m_beats     = 0;
        if (abort) begin
            e_oe      = 8'h00;
            e_out     = 8'h00;
            m_cur_dir = 1'b0;
        end
    endtask

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_owner = -1; m_turn_left = 0; m_ptr = 0; m_beats = 0;
            m_cur_dir = 1'b0; m_own_dir = 1'b0;
            e_gnt = '0; e_oe = '0; e_out = '0; e_rd = '0; e_rv = 1'b0; e_busy = 1'b0;
        end else begin
            e_rv = 1'b0;
            if (m_owner < 0) begin
                if (ena && req != 4'h0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && bit_at(req, (m_ptr + k) % N)) w = (m_ptr + k) % N;
                    end
                    m_owner   = w;
                    m_own_dir = bit_at(dir, w);
                    m_beats   = 0;
                    e_busy    = 1'b1;
                    if (m_own_dir != m_cur_dir && TA > 0) begin
                        m_turn_left = TA;
                        e_oe        = 8'h00;
                        e_out       = 8'h00;
                    end else begin
                        m_grant();
                    end
                end
            end else if (!ena) begin
                m_drop(1'b1);
            end else if (m_turn_left > 0) begin
                m_turn_left--;
                if (m_turn_left == 0) m_grant();
            end else if (!bit_at(req, m_owner)) begin
                m_drop(1'b0);
            end else begin
                if (m_own_dir) begin
                    e_out = 8'(wdata >> (8 * m_owner));
                end else begin
                    e_rd = uio_in;
                    e_rv = 1'b1;
                end
                m_beats++;
                if (bit_at(last, m_owner) || m_beats == MB) m_drop(1'b0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        rst_n = 1'b0; ena = 1'b1; req = '0; dir = '0; last = '0; wdata = '0; uio_in = '0;

        //           rst ena req    dir    last   wdata          uio_in   gnt    oe     out    rdata  rv busy
        vecs[0]  = '{0, 1, 4'hF, 4'h0, 4'h0, 32'h0,         8'h00,   4'h0, 8'h00, 8'h00, 8'h00, 0, 0};
        vecs[1]  = '{0, 1, 4'hF, 4'h0, 4'h0, 32'h0,         8'h00,   4'h0, 8'h00, 8'h00, 8'h00, 0, 0};
        vecs[2]  = '{1, 1, 4'h4, 4'h4, 4'h0, 32'h00A5_0000, 8'h00,   4'h0, 8'h00, 8'h00, 8'h00, 0, 1};
        vecs[3]  = '{1, 1, 4'h4, 4'h4, 4'h0, 32'h00A5_0000, 8'h00,   4'h4, 8'hFF, 8'h00, 8'h00, 0, 1};
        vecs[4]  = '{1, 1, 4'h4, 4'h4, 4'h0, 32'h00A5_0000, 8'h00,   4'h4, 8'hFF, 8'hA5, 8'h00, 0, 1};
        vecs[5]  = '{1, 1, 4'h4, 4'h4, 4'h4, 32'h005A_0000, 8'h00,   4'h0, 8'hFF, 8'h5A, 8'h00, 0, 0};
        vecs[6]  = '{1, 1, 4'h0, 4'h0, 4'h0, 32'h0,         8'h00,   4'h0, 8'hFF, 8'h5A, 8'h00, 0, 0};
        vecs[7]  = '{1, 1, 4'h1, 4'h0, 4'h0, 32'h0,         8'h3C,   4'h0, 8'h00, 8'h00, 8'h00, 0, 1};
        vecs[8]  = '{1, 1, 4'h1, 4'h0, 4'h0, 32'h0,         8'h3C,   4'h1, 8'h00, 8'h00, 8'h00, 0, 1};
        vecs[9]  = '{1, 1, 4'h1, 4'h0, 4'h1, 32'h0,         8'h3C,   4'h0, 8'h00, 8'h00, 8'h3C, 1, 0};
        vecs[10] = '{1, 1, 4'h0, 4'h0, 4'h0, 32'h0,         8'h00,   4'h0, 8'h00, 8'h00, 8'h3C, 0, 0};
        vecs[11] = '{1, 1, 4'h8, 4'h0, 4'h0, 32'h0,         8'h00,   4'h8, 8'h00, 8'h00, 8'h3C, 0, 1};
        vecs[12] = '{1, 1, 4'h8, 4'h0, 4'h0, 32'h0,         8'h77,   4'h8, 8'h00, 8'h00, 8'h77, 1, 1};
        vecs[13] = '{1, 0, 4'h9, 4'h0, 4'h0, 32'h0,         8'h00,   4'h0, 8'h00, 8'h00, 8'h77, 0, 0};
        vecs[14] = '{1, 1, 4'h9, 4'h0, 4'h0, 32'h0,         8'h00,   4'h1, 8'h00, 8'h00, 8'h77, 0, 1};
        vecs[15] = '{1, 1, 4'h0, 4'h0, 4'h0, 32'h0,         8'h00,   4'h0, 8'h00, 8'h00, 8'h77, 0, 0};
        vecs[16] = '{1, 1, 4'h2, 4'h2, 4'h0, 32'h0000_C300, 8'h00,   4'h0, 8'h00, 8'h00, 8'h77, 0, 1};
        vecs[17] = '{1, 1, 4'h2, 4'h2, 4'h0, 32'h0000_C300, 8'h00,   4'h2, 8'hFF, 8'h00, 8'h77, 0, 1};
        vecs[18] = '{1, 1, 4'h2, 4'h2, 4'h0, 32'h0000_C300, 8'h00,   4'h2, 8'hFF, 8'hC3, 8'h77, 0, 1};
        vecs[19] = '{0, 1, 4'h2, 4'h2, 4'h0, 32'h0000_C300, 8'h00,   4'h0, 8'h00, 8'h00, 8'h00, 0, 0};
        vecs[20] = '{1, 1, 4'hF, 4'h0, 4'h0, 32'h0,         8'h00,   4'h1, 8'h00, 8'h00, 8'h00, 0, 1};

        for (int i = 0; i < 21; i++) begin
            rst_n = vecs[i].rst_n; ena = vecs[i].ena; req = vecs[i].req;
            dir = vecs[i].dir; last = vecs[i].last; wdata = vecs[i].wdata;
            uio_in = vecs[i].uio_in;
            tick();
            check($sformatf("vec%0d", i),
                  {gnt, uio_oe, uio_out, rdata, rdata_valid, busy},
                  {vecs[i].exp_gnt, vecs[i].exp_oe, vecs[i].exp_out,
                   vecs[i].exp_rdata, vecs[i].exp_rv, vecs[i].exp_busy});
        end

        // All four requesting reads continuously: full bursts of MB beats,
        // one idle cycle between owners, rotating 0,1,2,3,0.
        rst_n = 1'b0; req = 4'hF; dir = 4'h0; last = 4'h0; ena = 1'b1;
        tick();
        check("rot_reset", {gnt, uio_oe, busy}, {4'h0, 8'h00, 1'b0});
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            uio_in = 8'(c);
            tick();
            exp_g = (c % 5 == 4) ? 4'h0 : 4'(1 << ((c / 5) % 4));
            check($sformatf("rot%0d", c), {gnt, busy}, {exp_g, (c % 5 != 4)});
        end

        // Random traffic against the reference model, starting from reset.
        rst_n = 1'b0;
        tick();
        for (int c = 0; c < 1500; c++) begin
            rst_n  = ($urandom_range(99) != 0);
            ena    = ($urandom_range(15) != 0);
            req    = 4'($urandom | $urandom);
            dir    = 4'($urandom);
            last   = 4'($urandom & $urandom & $urandom);
            wdata  = $urandom;
            uio_in = 8'($urandom);
            tick();
            check($sformatf("rand%0d", c),
                  {gnt, uio_oe, uio_out, rdata, rdata_valid, busy},
                  {e_gnt, e_oe, e_out, e_rd, e_rv, e_busy});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
